// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and default timing parameters.
// The PARITY state exists only when UART_RX_PARITY_EN is defined.
package uart_pkg;

   // 50 MHz / 19200 baud / 16 oversample
   localparam int UART_BAUD_DIV_DEF = 163;
   // Oversample ticks per bit
   localparam int UART_SB_TICK_DEF  = 16;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_STOP   = 3'd3
`ifdef UART_RX_PARITY_EN
      ,
      ST_PARITY = 3'd4
`endif
   } uart_state_e;

endpackage : uart_pkg

// File: rtl/uart_baud_gen.sv
// Oversample tick generator: free-running counter that emits a one-clk tick
// every BAUD_DIV cycles, wrapping from BAUD_DIV-1 back to 0.
module uart_baud_gen
   import uart_pkg::*;
#(
   parameter int BAUD_DIV = UART_BAUD_DIV_DEF
) (
   input  logic clk,
   input  logic i_rst_n,
   output logic o_tick
);

   localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(BAUD_DIV - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Next count: wrap at the last value, otherwise increment
   always_comb begin
      cnt_d = cnt_q;
      if (cnt_q == LAST_CNT) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   // Counter register, runs continuously out of reset
   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign o_tick = (cnt_q == LAST_CNT);

endmodule : uart_baud_gen

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, LSB-first, one stop bit.
// Optional parity checking is enabled by defining UART_RX_PARITY_EN;
// without it o_parity_err is tied low and no parity state exists.
module uart_rx
   import uart_pkg::*;
#(
   parameter int NB_DATA    = 8,
   parameter int BAUD_DIV   = UART_BAUD_DIV_DEF,
   parameter int SB_TICK    = UART_SB_TICK_DEF,
   parameter bit PARITY_ODD = 1'b0
) (
   input  logic               clk,
   input  logic               i_rst_n,
   input  logic               i_rx,
   output logic [NB_DATA-1:0] o_rx_data,
   output logic               o_rx_done,
   output logic               o_frame_err,
   output logic               o_parity_err,
   output logic               o_busy
);

   localparam int CNT_W = (SB_TICK > 1) ? $clog2(SB_TICK) : 1;
   localparam int IDX_W = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;
   localparam logic [CNT_W-1:0] MID_CNT  = CNT_W'(SB_TICK / 2 - 1);
   localparam logic [CNT_W-1:0] END_CNT  = CNT_W'(SB_TICK - 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB_DATA - 1);

   logic               rx_meta_q;
   logic               rx_sync_q;
   logic               tick_s;
   uart_state_e        state_q, state_d;
   logic [CNT_W-1:0]   s_cnt_q, s_cnt_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [NB_DATA-1:0] shift_q, shift_d;
   logic [NB_DATA-1:0] data_q, data_d;
   logic               done_q, done_d;
   logic               ferr_q, ferr_d;
   logic               busy_q;

`ifdef UART_RX_PARITY_EN
   logic par_bad_q, par_bad_d;
   logic perr_q, perr_d;

   // XOR of all data bits (1 when the count of ones is odd)
   function automatic logic calc_parity(input logic [NB_DATA-1:0] d);
      return ^d;
   endfunction
`else
   logic unused_parity_odd_s;
   assign unused_parity_odd_s = PARITY_ODD;
`endif

   // Two-flop synchronizer for the asynchronous serial line, idles high
   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         rx_meta_q <= 1'b1;
         rx_sync_q <= 1'b1;
      end else begin
         rx_meta_q <= i_rx;
         rx_sync_q <= rx_meta_q;
      end
   end

   uart_baud_gen #(
      .BAUD_DIV (BAUD_DIV)
   ) u_baud_gen (
      .clk     (clk),
      .i_rst_n (i_rst_n),
      .o_tick  (tick_s)
   );

   // Frame FSM next-state, datapath and pulse decode
   always_comb begin
      state_d = state_q;
      s_cnt_d = s_cnt_q;
      idx_d   = idx_q;
      shift_d = shift_q;
      data_d  = data_q;
      done_d  = 1'b0;
      ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_d = par_bad_q;
      perr_d    = 1'b0;
`endif
      case (state_q)
         ST_IDLE: begin
            if (!rx_sync_q) begin
               state_d = ST_START;
               s_cnt_d = '0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_START: begin
            if (tick_s) begin
               if (s_cnt_q == MID_CNT) begin
                  if (!rx_sync_q) begin
                     state_d = ST_DATA;
                     s_cnt_d = '0;
                     idx_d   = '0;
`ifdef UART_RX_PARITY_EN
                     par_bad_d = 1'b0;
`endif
                  end else begin
                     // Start bit gone high at mid-bit: glitch, drop it
                     state_d = ST_IDLE;
                  end
               end else begin
                  s_cnt_d = s_cnt_q + CNT_W'(1);
               end
            end else begin
               s_cnt_d = s_cnt_q;
            end
         end
         ST_DATA: begin
            if (tick_s) begin
               if (s_cnt_q == END_CNT) begin
                  s_cnt_d = '0;
                  shift_d = NB_DATA'({rx_sync_q, shift_q} >> 1);
                  if (idx_q == LAST_IDX) begin
`ifdef UART_RX_PARITY_EN
                     state_d = ST_PARITY;
`else
                     state_d = ST_STOP;
`endif
                  end else begin
                     idx_d = idx_q + IDX_W'(1);
                  end
               end else begin
                  s_cnt_d = s_cnt_q + CNT_W'(1);
               end
            end else begin
               s_cnt_d = s_cnt_q;
            end
         end
`ifdef UART_RX_PARITY_EN
         ST_PARITY: begin
            if (tick_s) begin
               if (s_cnt_q == END_CNT) begin
                  s_cnt_d   = '0;
                  par_bad_d = ((calc_parity(shift_q) ^ rx_sync_q) != PARITY_ODD);
                  state_d   = ST_STOP;
               end else begin
                  s_cnt_d = s_cnt_q + CNT_W'(1);
               end
            end else begin
               s_cnt_d = s_cnt_q;
            end
         end
`endif
         ST_STOP: begin
            if (tick_s) begin
               if (s_cnt_q == END_CNT) begin
                  state_d = ST_IDLE;
                  s_cnt_d = '0;
                  if (rx_sync_q) begin
`ifdef UART_RX_PARITY_EN
                     if (par_bad_q) begin
                        perr_d = 1'b1;
                     end else begin
                        data_d = shift_q;
                        done_d = 1'b1;
                     end
`else
                     data_d = shift_q;
                     done_d = 1'b1;
`endif
                  end else begin
                     // Bad stop bit wins over a parity mismatch
                     ferr_d = 1'b1;
                  end
               end else begin
                  s_cnt_d = s_cnt_q + CNT_W'(1);
               end
            end else begin
               s_cnt_d = s_cnt_q;
            end
         end
         default: begin
            state_d = ST_IDLE;
            s_cnt_d = '0;
         end
      endcase
   end

   // State, datapath and registered output pulses
   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= ST_IDLE;
         s_cnt_q <= '0;
         idx_q   <= '0;
         shift_q <= '0;
         data_q  <= '0;
         done_q  <= 1'b0;
         ferr_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         s_cnt_q <= s_cnt_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         done_q  <= done_d;
         ferr_q  <= ferr_d;
         busy_q  <= (state_d != ST_IDLE);
      end
   end

`ifdef UART_RX_PARITY_EN
   // Parity mismatch flag and its error pulse
   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         par_bad_q <= 1'b0;
         perr_q    <= 1'b0;
      end else begin
         par_bad_q <= par_bad_d;
         perr_q    <= perr_d;
      end
   end

   assign o_parity_err = perr_q;
`else
   assign o_parity_err = 1'b0;
`endif

   assign o_rx_data   = data_q;
   assign o_rx_done   = done_q;
   assign o_frame_err = ferr_q;
   assign o_busy      = busy_q;

endmodule : uart_rx

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at 64 clk per bit (BAUD_DIV=4, SB_TICK=16).
// Define UART_RX_PARITY_EN to also exercise the even-parity frames.
module tb_uart_rx;

   localparam int BIT_CLK = 64;

   typedef struct {
      int         kind;   // 0 = done, 1 = frame error, 2 = parity error
      logic [7:0] data;   // expected o_rx_data while the pulse is high
   } ev_t;

   logic       clk;
   logic       rst_n;
   logic       rx;
   logic [7:0] rx_data;
   logic       rx_done;
   logic       frame_err;
   logic       parity_err;
   logic       busy;

   ev_t        exp_q[$];
   int         total;
   int         bad;
   int         cyc;
   int         stop_cyc;
   logic [7:0] last_good;
   logic       prev_pulse;
   logic       prev_busy;

   uart_rx #(
      .NB_DATA    (8),
      .BAUD_DIV   (4),
      .SB_TICK    (16),
      .PARITY_ODD (1'b0)
   ) dut (
      .clk          (clk),
      .i_rst_n      (rst_n),
      .i_rx         (rx),
      .o_rx_data    (rx_data),
      .o_rx_done    (rx_done),
      .o_frame_err  (frame_err),
      .o_parity_err (parity_err),
      .o_busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Free-running cycle counter for latency checks
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic send_bit(input logic b);
      rx = b;
      repeat (BIT_CLK) @(negedge clk);
   endtask

   // Send one frame and queue the response it must produce.
   task automatic send_frame(input logic [7:0] d, input logic stop_ok,
                             input logic par_flip, input int gap_bits);
      int kind;
      kind = !stop_ok ? 1 : (par_flip ? 2 : 0);
      if (kind == 0) last_good = d;
      exp_q.push_back('{kind, last_good});
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
      send_bit((^d) ^ par_flip);
`endif
      stop_cyc = cyc;
      if (stop_ok) begin
         send_bit(1'b1);
      end else begin
         // Low long enough to cover the mid-bit sample, then back to idle
         rx = 1'b0;
         repeat (40) @(negedge clk);
         rx = 1'b1;
         repeat (BIT_CLK - 40) @(negedge clk);
      end
      repeat (gap_bits * BIT_CLK) @(negedge clk);
   endtask

   // Monitor: pops the scoreboard whenever the DUT reports a frame result
   always @(negedge clk) begin
      if (rst_n === 1'b1 && (rx_done === 1'b1 || frame_err === 1'b1 || parity_err === 1'b1)) begin
         chk("pulse_onehot", 32'(rx_done) + 32'(frame_err) + 32'(parity_err), 32'd1);
         chk("pulse_width", 32'(prev_pulse), 32'd0);
         chk("busy_falls_with_pulse", {30'd0, prev_busy, busy}, 32'd2);
         chk("stop_sample_latency", 32'((cyc - stop_cyc) >= 26 && (cyc - stop_cyc) <= 42), 32'd1);
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_pulse: got done=%0b ferr=%0b perr=%0b expected none",
                     rx_done, frame_err, parity_err);
         end else begin
            chk("pulse_kind", rx_done ? 32'd0 : (frame_err ? 32'd1 : 32'd2), 32'(exp_q[0].kind));
            chk("rx_data", 32'(rx_data), 32'(exp_q[0].data));
            exp_q.pop_front();
         end
      end
      prev_pulse <= rx_done | frame_err | parity_err;
      prev_busy  <= busy;
   end

   initial begin
      total      = 0;
      bad        = 0;
      cyc        = 0;
      stop_cyc   = 0;
      last_good  = 8'h00;
      prev_pulse = 1'b0;
      prev_busy  = 1'b0;
      rst_n      = 1'b0;
      rx         = 1'b1;
      repeat (5) @(negedge clk);

      // Reset state
      chk("reset_rx_data", 32'(rx_data), 32'h0);
      chk("reset_done", 32'(rx_done), 32'h0);
      chk("reset_frame_err", 32'(frame_err), 32'h0);
      chk("reset_parity_err", 32'(parity_err), 32'h0);
      chk("reset_busy", 32'(busy), 32'h0);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);

      // Single good frame
      send_frame(8'hA5, 1'b1, 1'b0, 2);
      chk("a5_held", 32'(rx_data), 32'hA5);

      // Short glitch on the idle line
      rx = 1'b0;
      repeat (10) @(negedge clk);
      rx = 1'b1;
      repeat (5) @(negedge clk);
      chk("glitch_busy_high", 32'(busy), 32'h1);
      repeat (60) @(negedge clk);
      chk("glitch_busy_low", 32'(busy), 32'h0);
      chk("glitch_data_kept", 32'(rx_data), 32'hA5);

      // Back-to-back frames, no idle gap
      send_frame(8'h03, 1'b1, 1'b0, 0);
      send_frame(8'h05, 1'b1, 1'b0, 0);
      send_frame(8'h00, 1'b1, 1'b0, 2);

      // Good frame, then a frame with a low stop bit
      send_frame(8'h81, 1'b1, 1'b0, 2);
      send_frame(8'h3C, 1'b0, 1'b0, 2);
      chk("ferr_data_kept", 32'(rx_data), 32'h81);
      chk("ferr_busy_low", 32'(busy), 32'h0);

      // Reset during bit 4 of 0xFF
      send_bit(1'b0);
      for (int i = 0; i < 4; i++) send_bit(1'b1);
      rx = 1'b1;
      repeat (32) @(negedge clk);
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      last_good = 8'h00;
      chk("midframe_reset_busy", 32'(busy), 32'h0);
      chk("midframe_reset_data", 32'(rx_data), 32'h0);
      repeat (32 + 4 * BIT_CLK) @(negedge clk);
      chk("after_reset_idle", 32'(busy), 32'h0);
      send_frame(8'h12, 1'b1, 1'b0, 2);
      chk("after_reset_frame", 32'(rx_data), 32'h12);

`ifdef UART_RX_PARITY_EN
      // Even parity: 0x07 has odd weight, so the correct parity bit is 1
      send_frame(8'h07, 1'b1, 1'b1, 2);
      chk("perr_data_kept", 32'(rx_data), 32'h12);
      send_frame(8'h07, 1'b1, 1'b0, 2);
      chk("parity_ok_data", 32'(rx_data), 32'h07);
`endif

      repeat (200) @(negedge clk);
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_uart_rx
